// File: rtl/letter_glyph_renderer_if.sv
// Pixel-in / colour-out bundle for letter_glyph_renderer, including the glyph ROM port.
interface letter_glyph_renderer_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned COLOR_W = 8
);
    logic               in_valid;
    logic [4:0]         letter;
    logic [12:0]        pixel;
    logic               frame_start;
    logic [COLOR_W-1:0] fg_color;
    logic [COLOR_W-1:0] bg_color;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_data;
    logic [COLOR_W-1:0] color;
    logic               color_valid;

    // Layout stage, glyph ROM and colour mux side
    modport master (
        output in_valid, letter, pixel, frame_start, fg_color, bg_color, rom_data,
        input  rom_addr, color, color_valid
    );

    // Renderer side
    modport slave (
        input  in_valid, letter, pixel, frame_start, fg_color, bg_color, rom_data,
        output rom_addr, color, color_valid
    );
endinterface

// File: rtl/letter_glyph_renderer.sv
// Glyph renderer: (letter, pixel) -> glyph ROM lookup -> fg/bg colour, fixed 2-cycle latency.
// Define LGR_BLINK_EN to build the frame-based banner blink (SHOW/HIDE FSM + frame counter).
module letter_glyph_renderer #(
    parameter int unsigned GLYPH_DIM    = 50,
    parameter int unsigned NUM_GLYPHS   = 26,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned COLOR_W      = 8,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input logic                    clk,
    input logic                    resetn,
    letter_glyph_renderer_if.slave lgr
);
    localparam int unsigned LETTER_W   = 5;
    localparam int unsigned PIXEL_W    = 13;
    localparam int unsigned GLYPH_SIZE = GLYPH_DIM * GLYPH_DIM;

    localparam logic [LETTER_W:0]   LETTER_LIMIT = (LETTER_W + 1)'(NUM_GLYPHS);
    localparam logic [PIXEL_W:0]    PIXEL_LIMIT  = (PIXEL_W + 1)'(GLYPH_SIZE);
    localparam logic [ADDR_W-1:0]   GLYPH_SIZE_A = ADDR_W'(GLYPH_SIZE);

    // Elaboration-time sanity checks on the configuration
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end
    if (NUM_GLYPHS > 32) begin : g_bad_glyphs
        $error("NUM_GLYPHS exceeds the 5-bit letter code range");
    end
    if (64'(NUM_GLYPHS) * 64'(GLYPH_SIZE) > (64'(1) << ADDR_W)) begin : g_bad_addr
        $error("ADDR_W too narrow for the glyph ROM");
    end

    logic               hide;
    logic               blank0_c;
    logic [ADDR_W-1:0]  addr_c;
    logic               v1;
    logic               b1;
    logic               v2;
    logic               b2;

    assign blank0_c = ({1'b0, lgr.letter} >= LETTER_LIMIT) || ({1'b0, lgr.pixel} >= PIXEL_LIMIT);
    assign addr_c   = ADDR_W'(lgr.letter) * GLYPH_SIZE_A + ADDR_W'(lgr.pixel);

    // Stage 0: address generation; rom_addr holds across idle cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lgr.rom_addr <= '0;
            v1           <= 1'b0;
            b1           <= 1'b0;
        end else begin
            v1 <= lgr.in_valid;
            b1 <= blank0_c | hide;
            if (lgr.in_valid) begin
                lgr.rom_addr <= blank0_c ? '0 : addr_c;
            end
        end
    end

    // Stage 1: align control with the ROM's registered read
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v2 <= 1'b0;
            b2 <= 1'b0;
        end else begin
            v2 <= v1;
            b2 <= b1;
        end
    end

    // Stage 2: colour select; colours sampled here so changes hit the next output
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lgr.color       <= '0;
            lgr.color_valid <= 1'b0;
        end else begin
            lgr.color_valid <= v2;
            if (v2) begin
                lgr.color <= (lgr.rom_data && !b2) ? lgr.fg_color : lgr.bg_color;
            end else begin
                lgr.color <= '0;
            end
        end
    end

`ifdef LGR_BLINK_EN
    typedef enum logic {
        SHOW = 1'b0,
        HIDE = 1'b1
    } blink_state_t;

    localparam int unsigned         CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    blink_state_t       state;
    blink_state_t       state_nxt;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   frame_cnt_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= SHOW;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    // Count frames; flip phase after BLINK_FRAMES of them
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        if (lgr.frame_start) begin
            if (frame_cnt == CNT_LAST) begin
                state_nxt     = (state == SHOW) ? HIDE : SHOW;
                frame_cnt_nxt = '0;
            end else begin
                frame_cnt_nxt = frame_cnt + CNT_W'(1);
            end
        end
    end

    // Registered state means a coincident pixel sees the pre-toggle phase
    assign hide = (state == HIDE);
`else
    logic unused_frame_start;

    assign hide               = 1'b0;
    assign unused_frame_start = lgr.frame_start;
`endif

endmodule

// File: tb/tb_letter_glyph_renderer.sv
// Directed bench for letter_glyph_renderer; blink checks are built when LGR_BLINK_EN is defined.
module tb_letter_glyph_renderer;
    localparam logic [7:0] FG = 8'hF0;
    localparam logic [7:0] BG = 8'h0F;

    typedef struct {
        logic        v;
        logic [4:0]  l;
        logic [12:0] p;
        logic [15:0] e_addr;
        logic [7:0]  e_col;
        logic        e_val;
    } vec_t;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_bad;
    vec_t vecs [12];

    letter_glyph_renderer_if #(.ADDR_W(16), .COLOR_W(8)) lgr ();

    letter_glyph_renderer #(
        .GLYPH_DIM(50), .NUM_GLYPHS(26), .ADDR_W(16), .COLOR_W(8), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .lgr(lgr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph ROM stand-in: synchronous read, set bit at every even address
    always @(posedge clk) lgr.rom_data <= ~lgr.rom_addr[0];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] l, input logic [12:0] p, input logic fs);
        lgr.in_valid    = v;
        lgr.letter      = l;
        lgr.pixel       = p;
        lgr.frame_start = fs;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        resetn = 1'b1;
        lgr.fg_color = FG;
        lgr.bg_color = BG;
        drive(1'b0, 5'd0, 13'd0, 1'b0);

        vecs[0]  = '{1'b1, 5'd19, 13'd0,    16'd47500, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  13'd0,    16'd47500, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  13'd0,    16'd47500, FG,    1'b1};
        vecs[3]  = '{1'b1, 5'd27, 13'd5,    16'd0,     8'h00, 1'b0};
        vecs[4]  = '{1'b1, 5'd0,  13'd2500, 16'd0,     8'h00, 1'b0};
        vecs[5]  = '{1'b1, 5'd25, 13'd2499, 16'd64999, BG,    1'b1};
        vecs[6]  = '{1'b1, 5'd1,  13'd2,    16'd2502,  BG,    1'b1};
        vecs[7]  = '{1'b0, 5'd0,  13'd0,    16'd2502,  BG,    1'b1};
        vecs[8]  = '{1'b0, 5'd0,  13'd0,    16'd2502,  FG,    1'b1};
        vecs[9]  = '{1'b1, 5'd26, 13'd0,    16'd0,     8'h00, 1'b0};
        vecs[10] = '{1'b0, 5'd0,  13'd0,    16'd0,     8'h00, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  13'd0,    16'd0,     BG,    1'b1};

        // Reset state
        #1 resetn = 1'b0;
        #1;
        chk("reset rom_addr", 32'(lgr.rom_addr), 32'd0);
        chk("reset color", 32'(lgr.color), 32'd0);
        chk("reset color_valid", 32'(lgr.color_valid), 32'd0);
        cyc();
        cyc();
        resetn = 1'b1;

        // Table: outputs at each step reflect inputs two steps earlier
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].l, vecs[i].p, 1'b0);
            cyc();
            chk($sformatf("vec%0d rom_addr", i), 32'(lgr.rom_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d color", i), 32'(lgr.color), 32'(vecs[i].e_col));
            chk($sformatf("vec%0d color_valid", i), 32'(lgr.color_valid), 32'(vecs[i].e_val));
        end

        // Full-rate stream of letter 8, pixels 0..49
        for (int c = 0; c < 52; c++) begin
            drive(c < 50, 5'd8, 13'(c), 1'b0);
            cyc();
            chk($sformatf("stream%0d rom_addr", c), 32'(lgr.rom_addr),
                (c < 50) ? 32'(20000 + c) : 32'd20049);
            if (c >= 2) begin
                chk($sformatf("stream%0d color", c), 32'(lgr.color),
                    (((c - 2) % 2) == 0) ? 32'(FG) : 32'(BG));
                chk($sformatf("stream%0d color_valid", c), 32'(lgr.color_valid), 32'd1);
            end
        end
        drive(1'b0, 5'd0, 13'd0, 1'b0);
        cyc();
        chk("stream gap color", 32'(lgr.color), 32'd0);
        chk("stream gap color_valid", 32'(lgr.color_valid), 32'd0);

        // Colours are sampled at the output stage
        drive(1'b1, 5'd0, 13'd0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 13'd0, 1'b0);
        cyc();
        lgr.fg_color = 8'hAA;
        cyc();
        chk("late fg color", 32'(lgr.color), 32'hAA);
        lgr.fg_color = FG;

        // Mid-stream reset drops in-flight pixels
        drive(1'b1, 5'd2, 13'd0, 1'b0);
        cyc();
        drive(1'b1, 5'd2, 13'd1, 1'b0);
        cyc();
        drive(1'b1, 5'd2, 13'd2, 1'b0);
        cyc();
        chk("pre-reset color_valid", 32'(lgr.color_valid), 32'd1);
        chk("pre-reset color", 32'(lgr.color), 32'(FG));
        resetn = 1'b0;
        #1;
        chk("async reset color", 32'(lgr.color), 32'd0);
        chk("async reset color_valid", 32'(lgr.color_valid), 32'd0);
        chk("async reset rom_addr", 32'(lgr.rom_addr), 32'd0);
        drive(1'b0, 5'd0, 13'd0, 1'b0);
        cyc();
        resetn = 1'b1;
        cyc();
        chk("post-reset drop 1", 32'(lgr.color_valid), 32'd0);
        cyc();
        chk("post-reset drop 2", 32'(lgr.color_valid), 32'd0);
        drive(1'b1, 5'd2, 13'd0, 1'b0);
        cyc();
        chk("resume rom_addr", 32'(lgr.rom_addr), 32'd5000);
        chk("resume valid +1", 32'(lgr.color_valid), 32'd0);
        drive(1'b0, 5'd0, 13'd0, 1'b0);
        cyc();
        chk("resume valid +2 early", 32'(lgr.color_valid), 32'd0);
        cyc();
        chk("resume valid", 32'(lgr.color_valid), 32'd1);
        chk("resume color", 32'(lgr.color), 32'(FG));

`ifdef LGR_BLINK_EN
        // Two frames -> HIDE: set bits render background
        drive(1'b0, 5'd0, 13'd0, 1'b1);
        cyc();
        drive(1'b0, 5'd0, 13'd0, 1'b1);
        cyc();
        drive(1'b1, 5'd0, 13'd0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 13'd0, 1'b0);
        cyc();
        cyc();
        chk("hide color", 32'(lgr.color), 32'(BG));
        chk("hide color_valid", 32'(lgr.color_valid), 32'd1);
        // Toggle back to SHOW on a pixel edge: that pixel is old phase, next is new
        drive(1'b0, 5'd0, 13'd0, 1'b1);
        cyc();
        drive(1'b1, 5'd0, 13'd0, 1'b1);
        cyc();
        drive(1'b1, 5'd0, 13'd0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 13'd0, 1'b0);
        cyc();
        chk("toggle-edge pixel color", 32'(lgr.color), 32'(BG));
        cyc();
        chk("after-toggle pixel color", 32'(lgr.color), 32'(FG));
`else
        // frame_start has no effect without the blink feature
        drive(1'b0, 5'd0, 13'd0, 1'b1);
        cyc();
        drive(1'b0, 5'd0, 13'd0, 1'b1);
        cyc();
        drive(1'b1, 5'd0, 13'd0, 1'b1);
        cyc();
        drive(1'b0, 5'd0, 13'd0, 1'b0);
        cyc();
        cyc();
        chk("no-blink color", 32'(lgr.color), 32'(FG));
        chk("no-blink color_valid", 32'(lgr.color_valid), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
